// File: rtl/ring_ro_addr_seq.sv
`default_nettype none
// ============================================================================
// Module   : ring_ro_addr_seq
// Brief    : Readout address sequencer for the digitizer ring buffer.
//            On a start request the write pointer, offset, word count and
//            direction are latched. The ring is then walked newest-to-oldest
//            (backward) or oldest-to-newest (forward). The address advances
//            by one per serializer word acknowledge. DEPTH does not have to
//            be a power of two, because the address wraps modulo DEPTH.
// Ports    : sysclk       - system clock, rising edge
//            rst_n        - asynchronous active-low reset
//            wr_ptr_i     - ring write pointer (next location to be written)
//            offset_i     - words to skip back from the newest sample
//            howmany_i    - words to read out (clamped to DEPTH)
//            dir_i        - 0 backward / 1 forward
//            start_i      - readout request, sampled only in IDLE
//            abort_i      - cancel readout (wins over ack and start)
//            word_ack_i   - serializer finished the current word
//            address_o    - RAM read address, 0 when not valid
//            addr_valid_o - address_o is a readout address
//            busy_o       - sequencer not in IDLE
//            remaining_o  - words still to acknowledge
//            ro_done_o    - 1-cycle pulse on normal completion
//            cfg_err_o    - 1-cycle pulse when start rejected
//            timeout_o    - 1-cycle pulse on watchdog expiry
// Config   : RO_TIMEOUT_EN - enables the READ-state stall watchdog
//            (TIMEOUT_CYC cycles without a word_ack_i aborts the readout)
// Revision : 1.0 - initial release
// ============================================================================
module ring_ro_addr_seq #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 4096,
    parameter int CNT_W       = 12,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] wr_ptr_i,
    input  logic [ADDR_W-1:0] offset_i,
    input  logic [CNT_W-1:0]  howmany_i,
    input  logic              dir_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              word_ack_i,
    output logic [ADDR_W-1:0] address_o,
    output logic              addr_valid_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  remaining_o,
    output logic              ro_done_o,
    output logic              cfg_err_o,
    output logic              timeout_o
);

    // Signed working width for the start-address arithmetic.
    localparam int c_sw = ADDR_W + 2;
    // Width wide enough to compare a word count against DEPTH.
    localparam int c_cw = (CNT_W > ADDR_W + 1) ? CNT_W : ADDR_W + 1;

    localparam logic [ADDR_W:0]        c_depth_a = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_cw-1:0]        c_depth_c = c_cw'(DEPTH);
    localparam logic [CNT_W-1:0]       c_depth_n = CNT_W'(DEPTH);
    localparam logic signed [c_sw-1:0] c_depth_s = c_sw'(DEPTH);
    localparam logic signed [c_sw-1:0] c_one_s   = c_sw'(1);
    localparam logic [ADDR_W-1:0]      c_last    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0]      c_one_a   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]       c_one_c   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_wr, w_wr_nxt;
    logic [ADDR_W-1:0] r_off, w_off_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_dir, w_dir_nxt;
    logic [CNT_W-1:0]  r_rem, w_rem_nxt;
    logic              r_cfg_err, w_cfg_err_nxt;

    logic                   w_cfg_bad;
    logic [CNT_W-1:0]       w_cnt_clamped;
    logic signed [c_sw-1:0] w_base, w_wrap1, w_wrap2;
    logic [ADDR_W-1:0]      w_start_addr;
    logic [ADDR_W-1:0]      w_addr_step;

`ifdef RO_TIMEOUT_EN
    localparam int               c_wd_w   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_wd_w-1:0] c_wd_lim = c_wd_w'(TIMEOUT_CYC - 1);
    localparam logic [c_wd_w-1:0] c_wd_one = c_wd_w'(1);

    logic [c_wd_w-1:0] r_wd, w_wd_nxt;
    logic              r_timeout, w_timeout_nxt;
`endif

    // ------------------------------------------------------------------
    // Start-request qualification
    // ------------------------------------------------------------------
    assign w_cfg_bad = ({1'b0, wr_ptr_i} >= c_depth_a) ||
                       ({1'b0, offset_i} >= c_depth_a);
    assign w_cnt_clamped = (c_cw'(howmany_i) > c_depth_c) ? c_depth_n : howmany_i;

    // ------------------------------------------------------------------
    // Start address from the latched configuration. The backward result is
    // never below -DEPTH. The forward result is never below -2*DEPTH+1.
    // At most two DEPTH corrections are therefore needed.
    // ------------------------------------------------------------------
    always_comb begin
        w_base = $signed(c_sw'(r_wr)) - $signed(c_sw'(r_off))
               - (r_dir ? $signed(c_sw'(r_rem)) : c_one_s);
        w_wrap1 = w_base[c_sw-1]  ? (w_base + c_depth_s)  : w_base;
        w_wrap2 = w_wrap1[c_sw-1] ? (w_wrap1 + c_depth_s) : w_wrap1;
        w_start_addr = ADDR_W'(w_wrap2);
    end

    // Next address along the ring, wrapping at the DEPTH boundary.
    assign w_addr_step = r_dir ? ((r_addr == c_last) ? '0 : (r_addr + c_one_a))
                               : ((r_addr == '0) ? c_last : (r_addr - c_one_a));

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_nxt      = r_wr;
        w_off_nxt     = r_off;
        w_dir_nxt     = r_dir;
        w_rem_nxt     = r_rem;
        w_addr_nxt    = r_addr;
        w_cfg_err_nxt = 1'b0;
`ifdef RO_TIMEOUT_EN
        w_wd_nxt      = r_wd;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    if (w_cfg_bad) begin
                        w_cfg_err_nxt = 1'b1;
                    end else begin
                        w_wr_nxt    = wr_ptr_i;
                        w_off_nxt   = offset_i;
                        w_dir_nxt   = dir_i;
                        w_rem_nxt   = w_cnt_clamped;
                        w_state_nxt = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (abort_i) begin
                    w_rem_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_rem == '0) begin
                    // An empty request still passes through SETUP. The done
                    // pulse then has the same latency as the first address.
                    w_state_nxt = S_DONE;
                end else begin
                    w_addr_nxt  = w_start_addr;
                    w_state_nxt = S_READ;
`ifdef RO_TIMEOUT_EN
                    w_wd_nxt    = '0;
`endif
                end
            end
            S_READ: begin
                if (abort_i) begin
                    w_rem_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (word_ack_i) begin
`ifdef RO_TIMEOUT_EN
                    w_wd_nxt = '0;
`endif
                    if (r_rem == c_one_c) begin
                        w_rem_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_rem_nxt  = r_rem - c_one_c;
                        w_addr_nxt = w_addr_step;
                    end
                end
`ifdef RO_TIMEOUT_EN
                else if (r_wd == c_wd_lim) begin
                    w_rem_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_wd_nxt = r_wd + c_wd_one;
                end
`endif
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wr      <= '0;
            r_off     <= '0;
            r_dir     <= 1'b0;
            r_rem     <= '0;
            r_addr    <= '0;
            r_cfg_err <= 1'b0;
`ifdef RO_TIMEOUT_EN
            r_wd      <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_wr      <= w_wr_nxt;
            r_off     <= w_off_nxt;
            r_dir     <= w_dir_nxt;
            r_rem     <= w_rem_nxt;
            r_addr    <= w_addr_nxt;
            r_cfg_err <= w_cfg_err_nxt;
`ifdef RO_TIMEOUT_EN
            r_wd      <= w_wd_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_busy, w_valid;

    assign w_busy       = (r_state != S_IDLE);
    assign w_valid      = (r_state == S_READ);
    assign busy_o       = w_busy;
    assign addr_valid_o = w_valid;
    assign address_o    = w_valid ? r_addr : '0;
    assign remaining_o  = w_busy ? r_rem : '0;
    // An abort in the DONE cycle suppresses the completion pulse.
    assign ro_done_o    = (r_state == S_DONE) && !abort_i;
    assign cfg_err_o    = r_cfg_err;

`ifdef RO_TIMEOUT_EN
    assign timeout_o = r_timeout;
`else
    // Watchdog compiled out. timeout_o is tied low for every TIMEOUT_CYC.
    if (TIMEOUT_CYC > 0) begin : g_wd_off
        assign timeout_o = 1'b0;
    end else begin : g_wd_off_zero
        assign timeout_o = 1'b0;
    end
`endif

endmodule
`default_nettype wire
